arb_rr4_decode: RTL

Four-requester round-robin arbiter that shares one decoded resource slot among four clients. It picks a winner, holds the grant until the winner releases it or a hold timeout expires, and drives the winner's 2-bit index with an enable into the team's 2-to-4 decoder stage. It also provides the one-hot grant vector directly. It sits between the client request lines and the decoder-enabled datapath select.

---
 rtl/arb_rr4_decode.sv | 133 +++++++++++++
 1 files changed

// File: rtl/arb_rr4_decode.sv
// Four-client round-robin arbiter with hold timeout. It drives a registered one-hot
// grant plus the winner's index and an enable for a downstream 2-to-4 decoder.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no owner; pick a winner from req starting at ptr
// S_GRANT | gnt_idx owns the slot until done, req drop, or hold expiry
module arb_rr4_decode #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_en,
    output logic       timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_en_q, gnt_en_d;
    logic       timeout_q, timeout_d;

    logic [1:0] winner;
    logic       win_done;
    logic       win_req;
    logic       hold_expired;
    logic       release_now;

    // Highest offset is scanned first so the lowest offset from ptr wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic [1:0] k;
        w = p;
        for (int i = 3; i >= 0; i--) begin
            k = p + i[1:0];
            if (r[k]) begin
                w = k;
            end
        end
        return w;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] v;
        v      = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        winner       = rr_pick(req, ptr_q);
        win_done     = done[gnt_idx_q];
        win_req      = req[gnt_idx_q];
        hold_expired = (cnt_q == MAX_HOLD_C);
        release_now  = win_done || !win_req || hold_expired;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        timeout_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                gnt_d = 4'b0000;
                if (req != 4'b0000) begin
                    state_d   = S_GRANT;
                    gnt_d     = onehot(winner);
                    gnt_idx_d = winner;
                    cnt_d     = 8'd1;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    state_d   = S_IDLE;
                    gnt_d     = 4'b0000;
                    ptr_d     = gnt_idx_q + 2'd1;
                    timeout_d = hold_expired && !win_done && win_req;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase

        gnt_en_d = |gnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= 8'd0;
            gnt_q     <= 4'b0000;
            gnt_idx_q <= 2'd0;
            gnt_en_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_en_q  <= gnt_en_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_en  = gnt_en_q;
    assign timeout = timeout_q;

endmodule
